reg_alu_pipe: RTL and testbench
===============================

# reg_alu_pipe

Two-stage pipelined register-file/ALU execute datapath, the parametrised successor to the single-cycle register file + ALU block. Operands are read (with bypass) and latched in stage RD, executed and written back in stage EX. Adds a valid/ready input handshake, stall, EX→RD forwarding, hardwired x0, an extended ALU op set, and a registered result/flag output for the control path and testbench.

## Interface
- `D_WIDTH`, 32: datapath width.
- `A_WIDTH`, 5: register address width; depth = 2**A_WIDTH.
- `A0_INDEX`, 10: register index tapped onto `a0`.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  op presented this cycle.
- `in_ready`  out  1  op accepted when `in_valid && in_ready`.
- `ad1`, `ad2`  in  A_WIDTH  source register addresses.
- `ad3`  in  A_WIDTH  destination register address.
- `we3`  in  1  write-back enable for this op.
- `imm_op`  in  D_WIDTH  immediate operand.
- `alusrc`  in  1  0: op2 = reg[ad2]; 1: op2 = imm_op.
- `aluctrl`  in  4  ALU operation (package enum).
- `stall`  in  1  freeze both stages.
- `out_valid`  out  1  one-cycle pulse per completed op.
- `result`  out  D_WIDTH  registered ALU result.
- `eq`  out  1  registered (op1 == op2).
- `a0`  out  D_WIDTH  current contents of reg[A0_INDEX].

## Operation
- Register array: 2**A_WIDTH × D_WIDTH. reg[0] reads 0 always; writes to index 0 are dropped.
- RD stage, on accepting edge: op1/op2 resolved, then latched into RD/EX with ad3, we3, aluctrl; `ex_valid` ← 1. No accept → `ex_valid` ← 0 (unless stalled).
- Operand resolution per source: if src == 0 → 0; else if `ex_valid && ex_we3 && ex_ad3 == src` → current EX ALU output (forward); else reg[src]. Forwarding applies to ad2 only when `alusrc == 0`.
- EX stage, on edge with `ex_valid && !stall`: reg[ex_ad3] ← aluout if `ex_we3 && ex_ad3 != 0`; `result` ← aluout; `eq` ← (ex_op1 == ex_op2); `out_valid` ← 1. Otherwise `out_valid` ← 0, `result`/`eq` hold.
- ALU (aluctrl): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA; 10–15 → 0. Shift amount = op2[$clog2(D_WIDTH)-1:0]; upper bits ignored. ADD/SUB wrap modulo 2**D_WIDTH. SLT/SLTU return 1 or 0, zero-extended.
- `in_ready = !stall`. During stall: RD/EX holds, no write-back, no accept.
- `a0` reflects reg[A0_INDEX] combinationally; updates the cycle after the writing edge.

## Timing
- Reset (async, immediate): all registers 0, `ex_valid` 0, `out_valid` 0, `result` 0, `eq` 0, `a0` 0. Reset mid-operation flushes the in-flight op; no write-back occurs.
- Latency: op accepted at edge N → write-back and `result`/`out_valid` at edge N+1; `out_valid` high for the cycle following N+1.
- Throughput: one op per cycle; back-to-back dependent ops need no bubbles.
- Stall held k cycles with op in EX → its write-back and `out_valid` deferred exactly k cycles, issued once.
- Simultaneous write-back and read of the same register at one edge: reader sees new value (via forwarding).

## Structure
- `reg_alu_pkg`: `aluctrl_t` enum (ALU_ADD … ALU_SRA), ALU_CTRL_W = 4.
- Sub-module `alu_ext`: combinational ALU (op1, op2, aluctrl → aluout), parametrised by D_WIDTH.
- Register array, forwarding muxes, and RD/EX/output registers live in `reg_alu_pipe`.

## Test plan
- Reset during active traffic → `a0`=0, `result`=0, `out_valid`=0 immediately; following read of x5 returns 0.
- ADD x10 = x0 + imm 5 (alusrc=1, we3=1) accepted edge N → `out_valid` after N+1, `result`=5, `eq`=0, `a0`=5.
- x1 = x0+7, next cycle x2 = x1+x1 (alusrc=0) → second `result`=14 (forwarded), reg x2 = 14.
- x0 = x0+9 then x3 = x0+x0 → second `result`=0; no forwarding from x0.
- Op in EX, `stall`=1 for 3 cycles → `in_ready`=0, `out_valid`=0, target reg unchanged; release → single `out_valid` pulse with correct `result`.
- SRA 0x80000000 by 4 → 0xF8000000; SLT 0xFFFFFFFF,1 → 1; SLTU same → 0; SUB 3,3 → 0 with `eq`=1; aluctrl 15 → 0.

Source files
------------

// File: rtl/reg_alu_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_alu_pkg : ALU operation encoding shared by the execute datapath  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package reg_alu_pkg;

   localparam int ALU_CTRL_W = 4;

   typedef enum logic [ALU_CTRL_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } aluctrl_t;

endpackage
`default_nettype wire

// File: rtl/reg_alu_pipe_alu_ext.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_ext : combinational ALU, codes 10-15 yield zero                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_ext
   import reg_alu_pkg::*;
#(
   parameter int D_WIDTH = 32
) (
   input  logic [D_WIDTH-1:0]    op1,
   input  logic [D_WIDTH-1:0]    op2,
   input  logic [ALU_CTRL_W-1:0] aluctrl,
   output logic [D_WIDTH-1:0]    aluout
);

   localparam int SH_W = $clog2(D_WIDTH);

   logic [SH_W-1:0] shamt;
   assign shamt = op2[SH_W-1:0];

   always_comb begin
      aluout = '0;
      case (aluctrl)
         ALU_ADD:  aluout = op1 + op2;
         ALU_SUB:  aluout = op1 - op2;
         ALU_AND:  aluout = op1 & op2;
         ALU_OR:   aluout = op1 | op2;
         ALU_XOR:  aluout = op1 ^ op2;
         ALU_SLT:  aluout = {{(D_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
         ALU_SLTU: aluout = {{(D_WIDTH-1){1'b0}}, (op1 < op2)};
         ALU_SLL:  aluout = op1 << shamt;
         ALU_SRL:  aluout = op1 >> shamt;
         ALU_SRA:  aluout = $unsigned($signed(op1) >>> shamt);
         default:  aluout = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/reg_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_alu_pipe : two-stage register-file/ALU datapath with forwarding  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module reg_alu_pipe
   import reg_alu_pkg::*;
#(
   parameter int D_WIDTH  = 32,
   parameter int A_WIDTH  = 5,
   parameter int A0_INDEX = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [A_WIDTH-1:0]    ad1,
   input  logic [A_WIDTH-1:0]    ad2,
   input  logic [A_WIDTH-1:0]    ad3,
   input  logic                  we3,
   input  logic [D_WIDTH-1:0]    imm_op,
   input  logic                  alusrc,
   input  logic [ALU_CTRL_W-1:0] aluctrl,
   input  logic                  stall,
   output logic                  out_valid,
   output logic [D_WIDTH-1:0]    result,
   output logic                  eq,
   output logic [D_WIDTH-1:0]    a0
);

   localparam int DEPTH = 2**A_WIDTH;

   logic [D_WIDTH-1:0]    regs_q [DEPTH];
   logic [D_WIDTH-1:0]    regs_d [DEPTH];

   logic                  ex_valid_q,   ex_valid_d;
   logic                  ex_we3_q,     ex_we3_d;
   logic [A_WIDTH-1:0]    ex_ad3_q,     ex_ad3_d;
   logic [ALU_CTRL_W-1:0] ex_aluctrl_q, ex_aluctrl_d;
   logic [D_WIDTH-1:0]    ex_op1_q,     ex_op1_d;
   logic [D_WIDTH-1:0]    ex_op2_q,     ex_op2_d;
   logic                  out_valid_q,  out_valid_d;
   logic [D_WIDTH-1:0]    result_q,     result_d;
   logic                  eq_q,         eq_d;

   logic                  accept;
   logic                  fire;
   logic                  wb_en;
   logic [D_WIDTH-1:0]    aluout;
   logic [D_WIDTH-1:0]    op1_rd;
   logic [D_WIDTH-1:0]    op2_rd;

   assign in_ready  = !stall;
   assign accept    = in_valid && !stall;
   assign fire      = ex_valid_q && !stall;
   assign wb_en     = fire && ex_we3_q && (ex_ad3_q != '0);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign eq        = eq_q;
   assign a0        = regs_q[A0_INDEX];

   alu_ext #(
      .D_WIDTH (D_WIDTH)
   ) u_alu (
      .op1     (ex_op1_q),
      .op2     (ex_op2_q),
      .aluctrl (ex_aluctrl_q),
      .aluout  (aluout)
   );

   // The op in EX has not written back yet, so its ALU output is the
   // freshest value of its destination.
   always_comb begin
      op1_rd = regs_q[ad1];
      if (ad1 == '0)
         op1_rd = '0;
      else if (ex_valid_q && ex_we3_q && (ex_ad3_q == ad1))
         op1_rd = aluout;

      op2_rd = regs_q[ad2];
      if (alusrc)
         op2_rd = imm_op;
      else if (ad2 == '0)
         op2_rd = '0;
      else if (ex_valid_q && ex_we3_q && (ex_ad3_q == ad2))
         op2_rd = aluout;
   end

   always_comb begin
      ex_valid_d   = stall ? ex_valid_q : accept;
      ex_we3_d     = accept ? we3     : ex_we3_q;
      ex_ad3_d     = accept ? ad3     : ex_ad3_q;
      ex_aluctrl_d = accept ? aluctrl : ex_aluctrl_q;
      ex_op1_d     = accept ? op1_rd  : ex_op1_q;
      ex_op2_d     = accept ? op2_rd  : ex_op2_q;

      out_valid_d  = fire;
      result_d     = fire ? aluout : result_q;
      eq_d         = fire ? (ex_op1_q == ex_op2_q) : eq_q;

      regs_d = regs_q;
      if (wb_en)
         regs_d[ex_ad3_q] = aluout;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q       <= '{default: '0};
         ex_valid_q   <= 1'b0;
         ex_we3_q     <= 1'b0;
         ex_ad3_q     <= '0;
         ex_aluctrl_q <= '0;
         ex_op1_q     <= '0;
         ex_op2_q     <= '0;
         out_valid_q  <= 1'b0;
         result_q     <= '0;
         eq_q         <= 1'b0;
      end else begin
         regs_q       <= regs_d;
         ex_valid_q   <= ex_valid_d;
         ex_we3_q     <= ex_we3_d;
         ex_ad3_q     <= ex_ad3_d;
         ex_aluctrl_q <= ex_aluctrl_d;
         ex_op1_q     <= ex_op1_d;
         ex_op2_q     <= ex_op2_d;
         out_valid_q  <= out_valid_d;
         result_q     <= result_d;
         eq_q         <= eq_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_alu_pipe : directed self-checking bench for reg_alu_pipe      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_reg_alu_pipe;
   import reg_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  ad1, ad2, ad3;
   logic        we3;
   logic [31:0] imm_op;
   logic        alusrc;
   logic [3:0]  aluctrl;
   logic        stall;
   logic        out_valid;
   logic [31:0] result;
   logic        eq;
   logic [31:0] a0;

   int n_checks = 0;
   int n_fails  = 0;

   reg_alu_pipe #(
      .D_WIDTH  (32),
      .A_WIDTH  (5),
      .A0_INDEX (10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ad1       (ad1),
      .ad2       (ad2),
      .ad3       (ad3),
      .we3       (we3),
      .imm_op    (imm_op),
      .alusrc    (alusrc),
      .aluctrl   (aluctrl),
      .stall     (stall),
      .out_valid (out_valid),
      .result    (result),
      .eq        (eq),
      .a0        (a0)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one op for exactly one accepting edge.
   task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                        input logic we, input logic [31:0] imm, input logic src,
                        input logic [3:0] ctrl);
      ad1      = a1;
      ad2      = a2;
      ad3      = a3;
      we3      = we;
      imm_op   = imm;
      alusrc   = src;
      aluctrl  = ctrl;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // x5 = a, then scratch = x5 <op> imm b (forwarded), checked one edge later.
   task automatic alu_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] ctrl, input logic [31:0] exp, input logic exp_eq);
      issue(5'd0, 5'd0, 5'd5, 1'b1, a, 1'b1, ALU_ADD);
      issue(5'd5, 5'd0, 5'd6, 1'b1, b, 1'b1, ctrl);
      step();
      check(tag, result, exp);
      check({tag, "_eq"}, {31'd0, eq}, {31'd0, exp_eq});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; stall = 1'b0;
      ad1 = '0; ad2 = '0; ad3 = '0; we3 = 1'b0; imm_op = '0; alusrc = 1'b0; aluctrl = '0;
      step();
      step();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_eq", {31'd0, eq}, 32'd0);
      check("rst_a0", a0, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      step();

      // x10 = x0 + 5
      issue(5'd0, 5'd0, 5'd10, 1'b1, 32'd5, 1'b1, ALU_ADD);
      check("lat_no_early_valid", {31'd0, out_valid}, 32'd0);
      step();
      check("add_imm_valid", {31'd0, out_valid}, 32'd1);
      check("add_imm_result", result, 32'd5);
      check("add_imm_eq", {31'd0, eq}, 32'd0);
      check("add_imm_a0", a0, 32'd5);
      step();
      check("add_imm_pulse", {31'd0, out_valid}, 32'd0);

      // x1 = 7; x2 = x1 + x1 back-to-back
      issue(5'd0, 5'd0, 5'd1, 1'b1, 32'd7, 1'b1, ALU_ADD);
      issue(5'd1, 5'd1, 5'd2, 1'b1, 32'd0, 1'b0, ALU_ADD);
      check("fwd_first_result", result, 32'd7);
      step();
      check("fwd_second_valid", {31'd0, out_valid}, 32'd1);
      check("fwd_second_result", result, 32'd14);
      check("fwd_second_eq", {31'd0, eq}, 32'd1);
      issue(5'd2, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, ALU_ADD);
      step();
      check("x2_readback", result, 32'd14);

      // x0 write is dropped and never forwarded
      issue(5'd0, 5'd0, 5'd0, 1'b1, 32'd9, 1'b1, ALU_ADD);
      issue(5'd0, 5'd0, 5'd3, 1'b1, 32'd0, 1'b0, ALU_ADD);
      check("x0_first_result", result, 32'd9);
      step();
      check("x0_no_fwd_result", result, 32'd0);

      // stall three cycles with x10 = 0x55 sitting in EX
      issue(5'd0, 5'd0, 5'd10, 1'b1, 32'h55, 1'b1, ALU_ADD);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("stall_out_valid", {31'd0, out_valid}, 32'd0);
         check("stall_a0_hold", a0, 32'd5);
      end
      stall = 1'b0;
      step();
      check("unstall_valid", {31'd0, out_valid}, 32'd1);
      check("unstall_result", result, 32'h55);
      check("unstall_a0", a0, 32'h55);
      step();
      check("unstall_single_pulse", {31'd0, out_valid}, 32'd0);

      alu_chk("sra",      32'h8000_0000, 32'd4,         ALU_SRA,  32'hF800_0000, 1'b0);
      alu_chk("srl",      32'h8000_0000, 32'd4,         ALU_SRL,  32'h0800_0000, 1'b0);
      alu_chk("sll_wrap", 32'd1,         32'd33,        ALU_SLL,  32'd2,         1'b0);
      alu_chk("slt",      32'hFFFF_FFFF, 32'd1,         ALU_SLT,  32'd1,         1'b0);
      alu_chk("sltu",     32'hFFFF_FFFF, 32'd1,         ALU_SLTU, 32'd0,         1'b0);
      alu_chk("sub_eq",   32'd3,         32'd3,         ALU_SUB,  32'd0,         1'b1);
      alu_chk("add_wrap", 32'hFFFF_FFFF, 32'd2,         ALU_ADD,  32'd1,         1'b0);
      alu_chk("and",      32'hF0F0_1234, 32'h0FF0_FF00, ALU_AND,  32'h00F0_1200, 1'b0);
      alu_chk("or",       32'hF000_0001, 32'h0000_0F00, ALU_OR,   32'hF000_0F01, 1'b0);
      alu_chk("xor",      32'hAAAA_5555, 32'hFFFF_0000, ALU_XOR,  32'h5555_5555, 1'b0);
      alu_chk("ctrl15",   32'd12,        32'd34,        4'd15,    32'd0,         1'b0);

      // reset while x10 = 0x77 is in EX
      issue(5'd0, 5'd0, 5'd10, 1'b1, 32'h77, 1'b1, ALU_ADD);
      #1 rst = 1'b1;
      #1;
      check("async_rst_a0", a0, 32'd0);
      check("async_rst_result", result, 32'd0);
      check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      #1 rst = 1'b0;
      step();
      check("flush_no_valid", {31'd0, out_valid}, 32'd0);
      check("flush_a0", a0, 32'd0);
      issue(5'd5, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, ALU_ADD);
      step();
      check("post_rst_x5", result, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
